// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight destination registers in a shift pipeline
// and stalls issue when a source operand is still pending.
module reg_scoreboard #(
    parameter int unsigned REG_BITS = 3,
    parameter int unsigned DEPTH    = 3,
    parameter bit          BYPASS   = 1'b0,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned NUM_REGS = 2 ** REG_BITS,
    localparam int unsigned INF_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue,
    input  logic                flush,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    input  logic                rs_v,
    input  logic                rt_v,
    input  logic                rd_v,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic [INF_W-1:0]    inflight,
    output logic [CNT_W-1:0]    stall_cnt
);

    // With write-before-read, the oldest slot is already visible to the reader.
    localparam int WinDepth = (BYPASS != 1'b0) ? int'(DEPTH) - 1 : int'(DEPTH);

    logic [DEPTH-1:0]    slot_v_q, slot_v_d;
    logic [REG_BITS-1:0] slot_dst_q [DEPTH];
    logic [REG_BITS-1:0] slot_dst_d [DEPTH];
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                hit_rs, hit_rt, hazard;

    always_comb begin
        hit_rs   = 1'b0;
        hit_rt   = 1'b0;
        busy     = '0;
        inflight = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (slot_v_q[k]) begin
                busy[slot_dst_q[k]] = 1'b1;
                inflight            = inflight + INF_W'(1);
                if (k < WinDepth) begin
                    if (slot_dst_q[k] == rs) hit_rs = 1'b1;
                    if (slot_dst_q[k] == rt) hit_rt = 1'b1;
                end
            end
        end
        hazard = issue & ((rs_v & hit_rs) | (rt_v & hit_rt));
        stall  = hazard & ~flush;
    end

    // The downstream shift always advances; a stalled issue enters slot 0 as a bubble.
    always_comb begin
        slot_v_d      = '0;
        slot_dst_d[0] = rd;
        for (int k = 1; k < int'(DEPTH); k++) begin
            slot_v_d[k]   = slot_v_q[k-1];
            slot_dst_d[k] = slot_dst_q[k-1];
        end
        slot_v_d[0] = issue & rd_v & ~stall;
        if (flush) begin
            slot_v_d = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q    <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_dst_q[k] <= '0;
            end
        end else begin
            slot_v_q    <= slot_v_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_dst_q[k] <= slot_dst_d[k];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register-hazard scoreboard for the pipelined WISC core, sitting at the decode/issue boundary directly behind the register-identifier decode. It consumes decoded source/destination register fields with their valid bits. It tracks destination registers of in-flight instructions in a DEPTH-slot shift pipeline and raises a stall when an issuing instruction reads a register that is still pending. It also exposes a per-register busy vector, an in-flight count and a saturating stall-cycle counter for performance monitoring.

## Interface
- REG_BITS, 3, register index width; NUM_REGS = 2^REG_BITS.
- DEPTH, 3, slots between issue and register-file write (≥1).
- BYPASS, 0, 1 = register file writes before it reads, so a match in slot DEPTH-1 does not stall.
- CNT_W, 16, stall counter width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue  in  1  decode presents a valid instruction this cycle.
- flush  in  1  squash all in-flight entries (branch/jump redirect).
- rs, rt, rd  in  REG_BITS each  decoded source/source/destination indices.
- rs_v, rt_v, rd_v  in  1 each  field is used by the instruction.
- stall  out  1  combinational; hold decode and insert a bubble.
- busy  out  NUM_REGS  combinational; bit r = register r has a pending write.
- inflight  out  clog2(DEPTH+1)  combinational; number of valid slots.
- stall_cnt  out  CNT_W  registered; saturating count of stall cycles.

## Operation
- State: slot[0..DEPTH-1], each {v, dst[REG_BITS-1:0]}; slot 0 is youngest; slot DEPTH-1 retires next edge.
- Register 0 is an ordinary register; there is no hardwired-zero exclusion.
- Match window: slots 0..DEPTH-1 if BYPASS=0; slots 0..DEPTH-2 if BYPASS=1. With DEPTH=1 and BYPASS=1, stall is never asserted.
- hazard = issue & ((rs_v & rs hits a valid window slot) | (rt_v & rt hits a valid window slot)).
- stall = hazard & ~flush.
- busy[r] = OR over all valid slots (full depth, independent of BYPASS) of (dst == r). inflight = popcount of slot v bits.
- Next state, in priority order:
  - rst: all slot v = 0, stall_cnt = 0.
  - flush: all slot v = 0. stall_cnt is unchanged, since stall is 0 that cycle.
  - otherwise: slot[k] <= slot[k-1] for k ≥ 1, and slot[0] <= {issue & rd_v & ~stall, rd}.
  - The downstream shift always advances, including during stall. Slot 0 takes a bubble while stalled.
- stall_cnt: +1 on each cycle stall = 1, saturating at 2^CNT_W-1. It does not wrap.
- Instructions with rd_v = 0 (NOP, branches, JR) never occupy a slot. JAL/JALR occupy a slot with dst = 7 as decoded upstream.
- A self-dependency (rs == rd in the same instruction) does not stall; only older slots are compared.

## Timing
- Reset values: all slots invalid, busy = 0, inflight = 0, stall = 0 (given issue = 0 or no hit), stall_cnt = 0.
- stall, busy and inflight are combinational from current slots and inputs, with no added latency.
- An entry written at edge N is visible in slot 0 during cycle N+1 and retires after edge N+DEPTH.
- Read-after-write distance d (cycles after the producer issues):
  - BYPASS=0: stalls for max(0, DEPTH-d+1) cycles.
  - BYPASS=1: stalls for max(0, DEPTH-d) cycles.
- Simultaneous flush and issue: flush wins, stall = 0, and the issuing instruction is not recorded. Upstream discards it.
- rst asserted mid-stall: clears everything on that edge; stall drops the following cycle unless inputs re-hit.

## Test plan
- Reset: assert rst 2 cycles with random inputs -> busy = 0, inflight = 0, stall_cnt = 0, stall = 0 when issue = 0.
- RAW on rs, DEPTH=3, BYPASS=0: issue rd = 3, then next cycle issue rs = 3 held -> stall = 1 for exactly 3 cycles, then 0; stall_cnt = 3; busy[3] = 1 for 3 cycles.
- Same stimulus with BYPASS=1 -> stall for exactly 2 cycles; stall_cnt = 2.
- rt hit with rd_v = 0 producer: issue rd = 5, rd_v = 0, then rt = 5, rt_v = 1 -> stall never asserts, inflight stays 0. Then a real rd = 5 producer followed by a consumer with rt_v = 0, rt = 5 -> no stall.
- Flush: issue rd = 2 and rd = 4 back to back (inflight = 2), then flush together with issue rs = 2 -> stall = 0 that cycle; next cycle busy = 0, inflight = 0.
- Saturation, CNT_W=4: repeat the producer/consumer pair until 20 stall cycles have occurred -> stall_cnt reads 15 and holds; rst returns it to 0.
